// File: rtl/inst_mem_responder.sv
// rtl/inst_mem_responder.sv - instruction memory responder with fixed read latency and side load port
module inst_mem_responder #(
  parameter int INST_WIDTH      = 32,
  parameter int INST_ADDR_WIDTH = 7,
  parameter int LATENCY         = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       inst_we_core2mem,
  input  logic                       inst_request_core2mem,
  input  logic [INST_ADDR_WIDTH-1:0] inst_addr_core2mem,
  output logic                       inst_ready_mem2core,
  output logic                       inst_valid_mem2core,
  output logic [INST_WIDTH-1:0]      inst_mem2core,
  output logic [INST_ADDR_WIDTH-1:0] inst_addr_mem2core,
  output logic                       err_we,
  input  logic                       load_we,
  input  logic [INST_ADDR_WIDTH-1:0] load_addr,
  input  logic [INST_WIDTH-1:0]      load_data
);

  localparam int         DEPTH    = 1 << INST_ADDR_WIDTH;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
  localparam bit         SINGLE   = (LATENCY == 1);

  logic [INST_WIDTH-1:0]      mem_q [DEPTH];
  logic [1:0]                 state_q, state_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic [INST_WIDTH-1:0]      hold_data_q, hold_data_d;
  logic [INST_ADDR_WIDTH-1:0] hold_addr_q, hold_addr_d;
  logic [INST_WIDTH-1:0]      out_data_q, out_data_d;
  logic [INST_ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic                       err_q, err_d;
  logic                       accept;
  logic [INST_WIDTH-1:0]      rd_data;

  assign inst_ready_mem2core = (state_q != S_WAIT);
  assign inst_valid_mem2core = (state_q == S_RESP);
  assign inst_mem2core       = out_data_q;
  assign inst_addr_mem2core  = out_addr_q;
  assign err_we              = err_q;

  assign accept  = inst_ready_mem2core & inst_request_core2mem & ~inst_we_core2mem;
  // Array read sees the pre-edge contents, so a same-edge load returns the old word.
  assign rd_data = mem_q[inst_addr_core2mem];

  always_ff @(posedge clk) begin
    if (load_we) begin
      mem_q[load_addr] <= load_data;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_data_d = hold_data_q;
    hold_addr_d = hold_addr_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    err_d       = err_q;

    if (inst_request_core2mem && inst_we_core2mem) begin
      err_d = 1'b1;
    end

    case (state_q)
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = S_RESP;
          out_data_d = hold_data_q;
          out_addr_d = hold_addr_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        if (accept) begin
          hold_data_d = rd_data;
          hold_addr_d = inst_addr_core2mem;
          cnt_d       = CNT_INIT;
          if (SINGLE) begin
            state_d    = S_RESP;
            out_data_d = rd_data;
            out_addr_d = inst_addr_core2mem;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      hold_data_q <= '0;
      hold_addr_q <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_data_q <= hold_data_d;
      hold_addr_q <= hold_addr_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_inst_mem_responder.sv
// tb/tb_inst_mem_responder.sv - randomized and directed bench for inst_mem_responder at latencies 1, 2 and 4
module tb_inst_mem_responder;

  localparam int W  = 32;
  localparam int AW = 7;
  localparam int N  = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic          lwe = 1'b0;
  logic [AW-1:0] laddr = '0;
  logic [W-1:0]  ldata = '0;

  logic          ready_o [N];
  logic          valid_o [N];
  logic [W-1:0]  data_o  [N];
  logic [AW-1:0] aecho_o [N];
  logic          err_o   [N];

  always #5 clk = ~clk;

  inst_mem_responder #(.INST_WIDTH(W), .INST_ADDR_WIDTH(AW), .LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .inst_we_core2mem(we), .inst_request_core2mem(req),
    .inst_addr_core2mem(addr), .inst_ready_mem2core(ready_o[0]), .inst_valid_mem2core(valid_o[0]),
    .inst_mem2core(data_o[0]), .inst_addr_mem2core(aecho_o[0]), .err_we(err_o[0]),
    .load_we(lwe), .load_addr(laddr), .load_data(ldata));

  inst_mem_responder #(.INST_WIDTH(W), .INST_ADDR_WIDTH(AW), .LATENCY(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .inst_we_core2mem(we), .inst_request_core2mem(req),
    .inst_addr_core2mem(addr), .inst_ready_mem2core(ready_o[1]), .inst_valid_mem2core(valid_o[1]),
    .inst_mem2core(data_o[1]), .inst_addr_mem2core(aecho_o[1]), .err_we(err_o[1]),
    .load_we(lwe), .load_addr(laddr), .load_data(ldata));

  inst_mem_responder #(.INST_WIDTH(W), .INST_ADDR_WIDTH(AW), .LATENCY(4)) u_l4 (
    .clk(clk), .rst_n(rst_n), .inst_we_core2mem(we), .inst_request_core2mem(req),
    .inst_addr_core2mem(addr), .inst_ready_mem2core(ready_o[2]), .inst_valid_mem2core(valid_o[2]),
    .inst_mem2core(data_o[2]), .inst_addr_mem2core(aecho_o[2]), .err_we(err_o[2]),
    .load_we(lwe), .load_addr(laddr), .load_data(ldata));

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: one pending response per instance, timed in edge numbers.
  int          lat      [N] = '{1, 2, 4};
  logic [W-1:0] m_mem   [1 << AW];
  int          edge_n = 0;
  int          last_acc [N];
  int          due      [N];
  logic [W-1:0] pend_d  [N];
  int          pend_a   [N];
  logic [W-1:0] exp_d   [N];
  int          exp_a    [N];
  logic        exp_err  [N];
  int          resp_seen_l2_deadbeef = 0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic q, input logic w, input int a,
                      input logic lw, input int la, input logic [W-1:0] ld);
    rst_n = r; req = q; we = w; addr = AW'(a);
    lwe = lw; laddr = AW'(la); ldata = ld;
    @(posedge clk);
    edge_n++;
    for (int j = 0; j < N; j++) begin
      if (!r) begin
        last_acc[j] = -1000;
        due[j]      = -1;
        exp_d[j]    = '0;
        exp_a[j]    = 0;
        exp_err[j]  = 1'b0;
      end else begin
        if (q && w) exp_err[j] = 1'b1;
        if (q && !w && edge_n >= last_acc[j] + lat[j]) begin
          last_acc[j] = edge_n;
          due[j]      = edge_n + lat[j] - 1;
          pend_d[j]   = m_mem[a];
          pend_a[j]   = a;
        end
        if (due[j] == edge_n) begin
          exp_d[j] = pend_d[j];
          exp_a[j] = pend_a[j];
        end
      end
    end
    if (lw) m_mem[la] = ld;
    #1;
    for (int j = 0; j < N; j++) begin
      chk($sformatf("valid[L%0d]", lat[j]), W'(valid_o[j]), W'(r && due[j] == edge_n));
      chk($sformatf("ready[L%0d]", lat[j]), W'(ready_o[j]), W'(edge_n + 1 >= last_acc[j] + lat[j]));
      chk($sformatf("data[L%0d]", lat[j]), data_o[j], exp_d[j]);
      chk($sformatf("addr[L%0d]", lat[j]), W'(aecho_o[j]), W'(exp_a[j]));
      chk($sformatf("err_we[L%0d]", lat[j]), W'(err_o[j]), W'(exp_err[j]));
    end
    if (valid_o[1] && data_o[1] == 32'hDEADBEEF && aecho_o[1] == AW'(5)) resp_seen_l2_deadbeef++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, '0);
  endtask

  task automatic rd(input int a);
    step(1'b1, 1'b1, 1'b0, a, 1'b0, 0, '0);
  endtask

  task automatic ld(input int a, input logic [W-1:0] d);
    step(1'b1, 1'b0, 1'b0, 0, 1'b1, a, d);
  endtask

  initial begin
    // Fill the whole array while held in reset; loads must land during reset.
    for (int i = 0; i < (1 << AW); i++) step(1'b0, 1'b0, 1'b0, 0, 1'b1, i, $urandom);
    idle(2);

    // Directed: single read of a known word.
    ld(5, 32'hDEADBEEF);
    rd(5);
    idle(5);
    chk("l2_deadbeef_pulses", W'(resp_seen_l2_deadbeef), 32'd1);

    // Directed: held request stream, WAIT-cycle requests are dropped.
    for (int i = 0; i < 4; i++) ld(i, 32'h100 + W'(i));
    for (int i = 0; i < 4; i++) rd(i);
    idle(5);

    // Directed: back-to-back reads.
    for (int i = 0; i < 32; i++) ld(i, W'(i * 4));
    for (int i = 0; i < 32; i++) rd(i);
    idle(5);

    // Directed: same-edge load and read returns the old word.
    ld(7, 32'h1);
    idle(1);
    step(1'b1, 1'b1, 1'b0, 7, 1'b1, 7, 32'h2);
    idle(5);
    rd(7);
    idle(5);

    // Directed: write request sets the sticky error, reads continue.
    step(1'b1, 1'b1, 1'b1, 3, 1'b0, 0, '0);
    idle(3);
    rd(3);
    idle(5);
    step(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, '0);
    idle(2);

    // Directed: reset while the longer-latency instances are waiting.
    rd(9);
    idle(1);
    step(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, '0);
    idle(2);
    rd(10);
    idle(6);

    // Random traffic including overlapping loads, write requests and resets.
    for (int i = 0; i < 700; i++) begin
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0),
           $urandom_range(0, (1 << AW) - 1), ($urandom_range(0, 2) == 0),
           $urandom_range(0, 15), $urandom);
    end
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/inst_mem_responder.md
Name: inst_mem_responder

Overview:
Memory-side responder for the core's instruction-fetch interface. It accepts read requests from the core and returns the addressed instruction word after a fixed, parameterised latency, with a one-cycle valid pulse. It also provides a side load port that testbench or boot logic uses to fill the instruction array. It sits between five_stage_cpu's fetch port and the instruction storage.

Parameters:
INST_WIDTH, 32, instruction word width
INST_ADDR_WIDTH, 7, word address width; array depth = 2**INST_ADDR_WIDTH words
LATENCY, 2, response latency in cycles; legal range 1..15; other values are unsupported

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
inst_we_core2mem  input  1  core write-request flag (no write data on this interface)
inst_request_core2mem  input  1  core request strobe, sampled each rising edge
inst_addr_core2mem  input  INST_ADDR_WIDTH  request word address
inst_ready_mem2core  output  1  high when a request sampled this edge will be accepted
inst_valid_mem2core  output  1  one-cycle pulse: response data valid
inst_mem2core  output  INST_WIDTH  response instruction word
inst_addr_mem2core  output  INST_ADDR_WIDTH  address of the current response (echo)
err_we  output  1  sticky flag: core issued a write request
load_we  input  1  side-load write enable
load_addr  input  INST_ADDR_WIDTH  side-load word address
load_data  input  INST_WIDTH  side-load data

Behaviour:
- Clock, reset: one clock. rst_n is synchronous, active-low. It is sampled on the rising edge of clk.
- Cycle n is the period after edge n. A request is "sampled at edge k" when request=1 in cycle k-1.
- Reset values: state=IDLE, inst_valid_mem2core=0, inst_mem2core=0, inst_addr_mem2core=0, err_we=0, latency counter=0. The array is not reset.
- Reset mid-operation: any in-flight request is dropped. Valid is 0 in the cycle after the reset edge. Loads in the reset cycle are still written.
- States: IDLE, WAIT, RESP.
- inst_ready_mem2core = (state != WAIT). It is a function of state only.
- Accept: at an edge where ready=1, request=1 and we=0:
  - the array is read at inst_addr_core2mem into a holding register, together with the address;
  - the counter is loaded with LATENCY-1;
  - next state = RESP if LATENCY==1, else WAIT.
- WAIT: the counter decrements each edge. When the counter reaches 1, next state = RESP.
- RESP: inst_valid_mem2core=1 for this single cycle. inst_mem2core and inst_addr_mem2core present the held data and address.
  - A new acceptable request in RESP is accepted, using the same rules as IDLE.
  - Otherwise next state = IDLE.
- Latency: a request sampled at edge k produces valid=1 in cycle k+LATENCY-1, i.e. it is registered at edge k+LATENCY-1. LATENCY=1 gives valid in cycle k. Throughput is one request per LATENCY cycles.
- Requests while ready=0 are ignored, not queued. The core must re-issue them.
- Data and address outputs hold their last value when valid=0.
- Write request (request=1, we=1, at any state): no response and no array change. err_we is set to 1 and stays set until reset. This does not affect an in-flight read.
- Side load: load_we=1 writes load_data to load_addr at the edge, in any state, including during reset.
  - Same-edge load and accepted read to the same address: the read returns the OLD word.
  - Loads after the accept edge do not alter an in-flight response.
- Address wrap: the full address range is valid. There is no out-of-range case.

Test Plan:
1. LATENCY=2. Load addr 5 with 0xDEADBEEF. Request addr 5 sampled at edge 10 -> valid=1 in cycle 11 only, data=0xDEADBEEF, addr echo=5. ready=0 in cycle 10.
2. LATENCY=2. Hold request=1 for addrs 0,1,2,3 on consecutive cycles (contents 0x100+i) -> responses only for addrs 0 and 2. Requests for 1 and 3 land in WAIT and are dropped.
3. LATENCY=1. Back-to-back requests for addrs 0..31, contents = addr*4 -> valid high in 32 consecutive cycles, each data = addr*4, ready never low.
4. At the same edge, load addr 7 = 0x2 (previous 0x1) and accept a read of addr 7 -> response 0x1. A re-read afterwards returns 0x2.
5. request=1, we=1, addr 3 -> no valid pulse, err_we=1 from the next cycle and persisting. A following read still works. rst_n=0 clears err_we.
6. LATENCY=4. Assert rst_n=0 while in WAIT -> no valid pulse, state IDLE, ready=1 after reset. A new request then responds after 4 cycles.
